// File: rtl/spi_master.sv
// SPI master, mode 0 (sclk idles low, data sampled on sclk rise).
// One frame = lead-in, 8 data periods, one commit period, trail-out.
//
// state  | meaning
// IDLE   | cs_n high, waiting for start
// LEAD   | cs_n low, sclk low, mosi shows bit 7 for CLK_DIV cycles
// XFER   | 8 data sclk periods, shift out on mosi / sample miso on rise
// COMMIT | one extra sclk period, mosi low, miso ignored
// TRAIL  | sclk low for CLK_DIV cycles before releasing cs_n
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEAD   = 3'd1;
  localparam logic [2:0] XFER   = 3'd2;
  localparam logic [2:0] COMMIT = 3'd3;
  localparam logic [2:0] TRAIL  = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [2:0] state;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic       half_end;

  assign half_end = (div_cnt == DIV_LAST);
  // cs_n is the registered busy flag inverted, so it never glitches on state decode.
  assign cs_n = ~busy;

  // Frame sequencer: divider, state, serial shift registers and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= 8'd0;
      bit_cnt <= 3'd0;
      tx_sh   <= 8'd0;
      rx_sh   <= 8'd0;
      rx_data <= 8'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      done    <= 1'b0;
      div_cnt <= half_end ? 8'd0 : div_cnt + 8'd1;
      case (state)
        IDLE: begin
          div_cnt <= 8'd0;
          sclk    <= 1'b0;
          mosi    <= 1'b0;
          if (start) begin
            state   <= LEAD;
            busy    <= 1'b1;
            tx_sh   <= tx_data;
            mosi    <= tx_data[7];
            rx_sh   <= 8'd0;
            bit_cnt <= 3'd0;
          end
        end
        LEAD: begin
          if (half_end) begin
            // first rise: bit 7 is re-presented, bit 7 of miso captured
            state <= XFER;
            sclk  <= 1'b1;
            mosi  <= tx_sh[7];
            tx_sh <= tx_sh << 1;
            rx_sh <= {rx_sh[6:0], miso};
          end
        end
        XFER: begin
          if (half_end) begin
            if (sclk) begin
              sclk <= 1'b0;
            end else if (bit_cnt == 3'd7) begin
              state <= COMMIT;
              sclk  <= 1'b1;
              mosi  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              sclk    <= 1'b1;
              mosi    <= tx_sh[7];
              tx_sh   <= tx_sh << 1;
              rx_sh   <= {rx_sh[6:0], miso};
            end
          end
        end
        COMMIT: begin
          if (half_end) begin
            if (sclk) sclk <= 1'b0;
            else      state <= TRAIL;
          end
        end
        TRAIL: begin
          if (half_end) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sh;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          sclk  <= 1'b0;
          mosi  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: one instance at CLK_DIV=4, one at CLK_DIV=1,
// a behavioural mode-0 slave on miso, and a frame-level reference model.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v = 1'b0;
  logic [7:0] tx_v = 8'd0;
  logic       sel = 1'b0;
  logic       tie_v = 1'b0;
  logic [7:0] slv_load = 8'd0;
  logic [7:0] slv_sh = 8'd0;
  logic       miso;

  logic       busy4, done4, sclk4, mosi4, cs4;
  logic [7:0] rx4;
  logic       busy1, done1, sclk1, mosi1, cs1;
  logic [7:0] rx1;

  logic       busy_v, done_v, sclk_v, mosi_v, cs_v;
  logic [7:0] rx_v;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_v & ~sel), .tx_data(tx_v),
    .busy(busy4), .done(done4), .rx_data(rx4), .sclk(sclk4),
    .mosi(mosi4), .miso(miso), .cs_n(cs4)
  );

  spi_master #(.CLK_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v & sel), .tx_data(tx_v),
    .busy(busy1), .done(done1), .rx_data(rx1), .sclk(sclk1),
    .mosi(mosi1), .miso(miso), .cs_n(cs1)
  );

  assign busy_v = sel ? busy1 : busy4;
  assign done_v = sel ? done1 : done4;
  assign sclk_v = sel ? sclk1 : sclk4;
  assign mosi_v = sel ? mosi1 : mosi4;
  assign cs_v   = sel ? cs1   : cs4;
  assign rx_v   = sel ? rx1   : rx4;

  // Slave: loads its byte when selected, shifts on each sclk fall.
  always @(negedge cs_v) slv_sh = slv_load;
  // Slave shift on sclk fall while selected.
  always @(negedge sclk_v) if (!cs_v) slv_sh = {slv_sh[6:0], 1'b0};
  assign miso = tie_v ? 1'b1 : slv_sh[7];

  typedef struct {
    bit         s;
    logic [7:0] tx;
    logic [7:0] sb;
    bit         tie;
    logic [7:0] exp_rx;
    int         exp_busy;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0] model_rx(input bit tie, input logic [7:0] sb);
    return tie ? 8'hFF : sb;
  endfunction

  function automatic int model_div(input bit s);
    return s ? 1 : 4;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One complete frame observed at negedge; optional mid-frame start poke.
  task automatic run_frame(input bit s, input logic [7:0] tx, input logic [7:0] sb,
                           input bit tie, input logic [7:0] exp_rx, input int exp_busy,
                           input bit poke, input logic [7:0] poke_tx, input string tag);
    int d;
    int busy_cnt;
    int rises;
    int rise1_t;
    int rise2_t;
    logic [7:0] cap;
    logic bit9;
    logic rise_mosi;
    bit stable;
    bit rx_early;
    bit done_seen;
    logic prev;
    logic [7:0] rx_before;
    d = model_div(s);
    sel = s;
    tie_v = tie;
    slv_load = sb;
    @(negedge clk);
    tx_v = tx;
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    rx_before = rx_v;
    busy_cnt = 0; rises = 0; rise1_t = 0; rise2_t = 0; cap = 8'd0; bit9 = 1'b1;
    rise_mosi = 1'b0; stable = 1; rx_early = 0; done_seen = 0; prev = 1'b0;
    for (int c = 0; c < 32 * d + 20; c++) begin
      if (done_v) begin
        done_seen = 1;
        break;
      end
      if (busy_v) busy_cnt++;
      if (sclk_v && !prev) begin
        rises++;
        rise_mosi = mosi_v;
        if (rises == 1) rise1_t = c;
        if (rises == 2) rise2_t = c;
        if (rises <= 8) cap = {cap[6:0], mosi_v};
        else bit9 = mosi_v;
        if (poke && rises == 3) begin
          start_v = 1'b1;
          tx_v = poke_tx;
        end
      end
      if (!sclk_v && prev && mosi_v !== rise_mosi) stable = 0;
      if (rx_v !== rx_before) rx_early = 1;
      prev = sclk_v;
      @(negedge clk);
      start_v = 1'b0;
    end
    check({tag, " done_seen"}, 32'(done_seen), 32'd1);
    check({tag, " busy_cycles"}, busy_cnt, exp_busy);
    check({tag, " sclk_rises"}, rises, 9);
    check({tag, " sclk_period"}, rise2_t - rise1_t, 2 * d);
    check({tag, " mosi_bits"}, 32'(cap), 32'(tx));
    check({tag, " mosi_commit"}, 32'(bit9), 32'd0);
    check({tag, " mosi_stable"}, 32'(stable), 32'd1);
    check({tag, " rx_held"}, 32'(rx_early), 32'd0);
    check({tag, " rx_data"}, 32'(rx_v), 32'(exp_rx));
    check({tag, " cs_n_at_done"}, 32'(cs_v), 32'd1);
    @(negedge clk);
    check({tag, " done_width_idle"}, {done_v, busy_v, sclk_v, mosi_v, cs_v}, 5'b00001);
  endtask

  initial begin
    int dq[$];
    int gq[$];
    int run;
    int rises;
    logic prev;
    bit no_done;

    vecs[0] = '{s: 1'b0, tx: 8'hA5, sb: 8'h3C, tie: 1'b0, exp_rx: 8'h00, exp_busy: 0};
    vecs[1] = '{s: 1'b0, tx: 8'h00, sb: 8'h12, tie: 1'b1, exp_rx: 8'h00, exp_busy: 0};
    vecs[2] = '{s: 1'b1, tx: 8'h81, sb: 8'h5A, tie: 1'b0, exp_rx: 8'h00, exp_busy: 0};
    for (int i = 3; i < 8; i++) begin
      vecs[i].s   = 1'($urandom_range(0, 1));
      vecs[i].tx  = 8'($urandom);
      vecs[i].sb  = 8'($urandom);
      vecs[i].tie = 1'($urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 8; i++) begin
      vecs[i].exp_rx   = model_rx(vecs[i].tie, vecs[i].sb);
      vecs[i].exp_busy = 20 * model_div(vecs[i].s);
    end

    repeat (3) @(negedge clk);
    check("reset_state_u4", {busy4, done4, sclk4, mosi4, cs4, rx4}, {5'b00001, 8'h00});
    check("reset_state_u1", {busy1, done1, sclk1, mosi1, cs1, rx1}, {5'b00001, 8'h00});
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {busy4, sclk4, mosi4, cs4, busy1, sclk1, mosi1, cs1}, 8'b00010001);

    for (int i = 0; i < 8; i++)
      run_frame(vecs[i].s, vecs[i].tx, vecs[i].sb, vecs[i].tie, vecs[i].exp_rx,
                vecs[i].exp_busy, 1'b0, 8'h00, $sformatf("vec%0d", i));

    // Start poked mid-XFER with different data must be ignored.
    run_frame(1'b0, 8'hA5, 8'hC3, 1'b0, model_rx(1'b0, 8'hC3), 80, 1'b1, 8'h5A, "poke");
    repeat (3) @(negedge clk);
    check("poke_no_queue", 32'(busy4), 32'd0);

    // Start held high: back-to-back frames.
    sel = 1'b0; tie_v = 1'b0; slv_load = 8'h69;
    tx_v = 8'hC3;
    start_v = 1'b1;
    run = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done_v) dq.push_back(c);
      if (cs_v) run++;
      else begin
        if (run > 0) gq.push_back(run);
        run = 0;
      end
    end
    start_v = 1'b0;
    check("hold_done_count", 32'(dq.size() >= 2), 32'd1);
    for (int i = 1; i < dq.size(); i++) check("hold_done_interval", dq[i] - dq[i-1], 81);
    check("hold_gap_count", 32'(gq.size() >= 1), 32'd1);
    foreach (gq[i]) check("hold_cs_gap", gq[i], 1);
    for (int c = 0; c < 200 && busy_v; c++) @(negedge clk);
    check("hold_drained", 32'(busy_v), 32'd0);
    @(negedge clk);
    check("hold_rx_nonzero", 32'(rx4 != 8'h00), 32'd1);

    // Reset at the 4th sclk rise aborts the frame.
    tx_v = 8'h33; slv_load = 8'h96;
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 200 && rises < 4; c++) begin
      if (sclk_v && !prev) rises++;
      prev = sclk_v;
      if (rises < 4) @(negedge clk);
    end
    check("abort_reached_rise4", rises, 4);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {sclk4, cs4, busy4, done4, mosi4, rx4}, {5'b01000, 8'h00});
    no_done = 1;
    repeat (3) begin
      @(negedge clk);
      if (done4 || rx4 !== 8'h00) no_done = 0;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done4 || busy4 || rx4 !== 8'h00) no_done = 0;
    end
    check("abort_no_done", 32'(no_done), 32'd1);

    run_frame(1'b0, 8'h5C, 8'hE7, 1'b0, model_rx(1'b0, 8'hE7), 80, 1'b0, 8'h00, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
